mp_add_ctrl: RTL and testbench

MP_ADD_CTRL -- requirements
Module: mp_add_ctrl

---
 rtl/mp_add_pkg.sv | 13 +
 rtl/cla_adder.sv | 39 +++
 rtl/mp_add_ctrl.sv | 125 ++++++++++++
 tb/tb_mp_add_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add/subtract controller:
// the slice width and the controller state encoding.
package mp_add_pkg;

    localparam int WORD = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_adder.sv
// Combinational carry-lookahead adder: 4-bit lookahead groups whose
// group carries ripple from one group to the next.
module cla_adder #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         c_out,
    output logic [W-1:0] sum
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c_in;
        // Every carry inside a group is expanded from the group carry-in only.
        for (int j = 0; j < W / 4; j++) begin
            c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+4] = g[4*j+3] | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
        end
        sum   = p ^ c[W-1:0];
        c_out = c[W];
    end

endmodule

// File: rtl/mp_add_ctrl.sv
// Multi-precision adder/subtractor: streams NWORDS slices of the operands
// through one shared cla_adder, least significant word first.
module mp_add_ctrl
    import mp_add_pkg::*;
#(
    parameter int NWORDS = 4,
    parameter int WORD   = mp_add_pkg::WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NWORDS*WORD-1:0] a,
    input  logic [NWORDS*WORD-1:0] b,
    input  logic                   sub,
    input  logic                   c_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [NWORDS*WORD-1:0] sum,
    output logic                   c_out,
    output state_t                 dbg_state_o
);

    localparam int TW = NWORDS * WORD;
    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic [TW-1:0]   a_q, a_d;
    logic [TW-1:0]   b_q, b_d;
    logic            sub_q, sub_d;
    logic [TW-1:0]   sum_q, sum_d;
    logic            cout_q, cout_d;

    logic [WORD-1:0] add_a;
    logic [WORD-1:0] add_b;
    logic [WORD-1:0] add_sum;
    logic            add_cout;

    // Subtraction is A + ~B + 1: B is inverted per slice, the +1 is the initial carry.
    assign add_a = a_q[int'(k_q)*WORD +: WORD];
    assign add_b = b_q[int'(k_q)*WORD +: WORD] ^ {WORD{sub_q}};

    cla_adder #(
        .W (WORD)
    ) u_adder (
        .a     (add_a),
        .b     (add_b),
        .c_in  (carry_q),
        .c_out (add_cout),
        .sum   (add_sum)
    );

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and a DONE result holds until taken.
    assign in_ready    = (state_q == IDLE) && !rst;
    assign res_valid   = (state_q == DONE);
    assign sum         = sum_q;
    assign c_out       = cout_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    k_d     = '0;
                    carry_d = sub ? 1'b1 : c_in;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(k_q)*WORD +: WORD] = add_sum;
                carry_d = add_cout;
                if (k_q == K_LAST) begin
                    cout_d  = add_cout;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

endmodule

// File: tb/tb_mp_add_ctrl.sv
// Self-checking bench for mp_add_ctrl: a 257-bit arithmetic reference model
// scored on every negative clock edge, plus directed literal expectations.
module tb_mp_add_ctrl;
    import mp_add_pkg::*;

    localparam int NW = 4;
    localparam int W  = 64;
    localparam int TW = NW * W;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          sub = 1'b0;
    logic          c_in = 1'b0;
    logic          res_ready = 1'b0;
    logic [TW-1:0] a = '0;
    logic [TW-1:0] b = '0;
    logic          in_ready;
    logic          res_valid;
    logic          c_out;
    logic [TW-1:0] sum;
    state_t        dbg_state;

    always #5 clk = ~clk;

    mp_add_ctrl #(
        .NWORDS (NW),
        .WORD   (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .sub         (sub),
        .c_in        (c_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .c_out       (c_out),
        .dbg_state_o (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [TW:0] act, input logic [TW:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT got none expected event", nm);
    endtask

    // {carry, sum}: A+B+cin, or 2^256 + A - B (top bit set means no borrow).
    function automatic logic [TW:0] model(input logic [TW-1:0] ma, input logic [TW-1:0] mb,
                                          input logic ms, input logic mc);
        if (ms) return {1'b1, ma} - {1'b0, mb};
        return {1'b0, ma} + {1'b0, mb} + {{TW{1'b0}}, mc};
    endfunction

    // ---------------- scoreboard ----------------
    logic [TW:0] exp_q[$];
    logic        busy = 1'b0;
    logic        model_valid = 1'b0;
    logic        rst_prev = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    logic [TW:0] last_res = '0;

    always @(negedge clk) begin
        state_t exp_state;
        cyc++;
        if (rst_prev) begin
            check("reset_sum", 257'(sum), '0);
            check("reset_c_out", 257'(c_out), '0);
            check("reset_res_valid", 257'(res_valid), '0);
        end
        model_valid = busy && ((cyc - acc_cyc) >= NW + 1);
        exp_state = !busy ? IDLE : (model_valid ? DONE : RUN);
        check("in_ready", 257'(in_ready), 257'(!busy && !rst));
        check("res_valid", 257'(res_valid), 257'(model_valid));
        check("state", 257'(dbg_state), 257'(exp_state));
        if (model_valid && exp_q.size() > 0)
            check("result", {c_out, sum}, exp_q[0]);
        if (rst) begin
            busy = 1'b0;
            exp_q.delete();
        end else if (model_valid && res_ready) begin
            last_res = {c_out, sum};
            void'(exp_q.pop_front());
            busy = 1'b0;
            done_cnt++;
        end else if (!busy && in_valid) begin
            busy = 1'b1;
            acc_cyc = cyc;
            exp_q.push_back(model(a, b, sub, c_in));
            acc_cnt++;
        end
        rst_prev = rst;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [TW-1:0] rand_word();
        logic [TW-1:0] r;
        for (int i = 0; i < TW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic op(input logic [TW-1:0] ta, input logic [TW-1:0] tb_v,
                      input logic ts, input logic tc, input int hold);
        int n_acc;
        int n_done;
        n_acc     = acc_cnt;
        n_done    = done_cnt;
        res_ready = (hold == 0);
        a         = ta;
        b         = tb_v;
        sub       = ts;
        c_in      = tc;
        in_valid  = 1'b1;
        for (int i = 0; i < 20 && acc_cnt == n_acc; i++) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc_cnt == n_acc) begin
            fail_now("accept");
            return;
        end
        a    = rand_word();
        b    = ~b;
        sub  = ~sub;
        c_in = ~c_in;
        if (hold > 0) begin
            for (int i = 0; i < 20 && !model_valid; i++) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < hold; i++) begin
                in_valid = i[0];
                a = rand_word();
                @(posedge clk);
                #1;
            end
            in_valid  = 1'b0;
            res_ready = 1'b1;
        end
        for (int i = 0; i < 30 && done_cnt == n_done; i++) begin
            @(posedge clk);
            #1;
        end
        if (done_cnt == n_done) fail_now("result");
    endtask

    task automatic reset_mid_run(input logic [TW-1:0] ta, input logic [TW-1:0] tb_v);
        int n_acc;
        n_acc     = acc_cnt;
        res_ready = 1'b1;
        a         = ta;
        b         = tb_v;
        sub       = 1'b0;
        c_in      = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 20 && acc_cnt == n_acc; i++) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc_cnt == n_acc) begin
            fail_now("accept_before_reset");
            return;
        end
        // Now in the k=0 cycle; two more edges reach k=2.
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("state_before_reset", 257'(dbg_state), 257'(RUN));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [TW-1:0] ones;
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;

    initial begin
        ones = '1;
        check("model_add_lit", model(256'd1, ones, 1'b0, 1'b0), {1'b1, {TW{1'b0}}});
        check("model_sub_lit", model(256'd5, 256'd7, 1'b1, 1'b0), {1'b0, ones - 256'd1});
        check("model_sub2_lit", model(256'd7, 256'd5, 1'b1, 1'b0), {1'b1, 256'd2});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        op(256'd1, ones, 1'b0, 1'b0, 0);
        check("add_wrap", last_res, {1'b1, {TW{1'b0}}});
        op(256'd5, 256'd7, 1'b1, 1'b1, 0);
        check("sub_borrow", last_res, {1'b0, ones - 256'd1});
        op(256'd7, 256'd5, 1'b1, 1'b0, 0);
        check("sub_no_borrow", last_res, {1'b1, 256'd2});
        op(256'd0, 256'd0, 1'b0, 1'b1, 0);
        check("carry_in", last_res, 257'd1);
        op({64'd3, 64'd0, 64'd0, ones[63:0]}, 256'd1, 1'b0, 1'b0, 10);
        check("backpressure", last_res, {1'b0, 64'd3, 64'd0, 64'd1, 64'd0});

        reset_mid_run(ones, ones);
        op(ones, 256'd1, 1'b0, 1'b1, 0);
        check("after_reset", last_res, {1'b1, 256'd1});

        for (int i = 0; i < 100; i++) begin
            ra = rand_word();
            rb = (i % 10 == 3) ? ra : rand_word();
            op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
